// File: rtl/ppcpu_mem_arbiter_pkg.sv
// PPCPU memory arbiter shared types.
// State encodings, width defaults and the grant picker.
package ppcpu_mem_arbiter_pkg;

  localparam int AW_DEF          = 32;
  localparam int DW_DEF          = 32;
  localparam int MAX_IF_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  // D has priority unless fetch has waited out its allowance
  function automatic grant_e pick_winner(
    input logic i_elig,
    input logic d_elig,
    input logic starved
  );
    grant_e g;
    g = GNT_NONE;
    unique case (1'b1)
      i_elig && (!d_elig || starved): g = GNT_I;
      d_elig && (!i_elig || !starved): g = GNT_D;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/ppcpu_mem_arbiter_if.sv
// PPCPU memory arbiter bus bundle.
// Fetch, data and memory handshakes plus stall outputs.
interface ppcpu_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          I_Req;
  logic [AW-1:0] I_Addr;
  logic [DW-1:0] I_Rdata;
  logic          I_Ack;

  logic          D_Req;
  logic          D_We;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D_Wdata;
  logic [DW-1:0] D_Rdata;
  logic          D_Ack;

  logic          M_Req;
  logic          M_We;
  logic [AW-1:0] M_Addr;
  logic [DW-1:0] M_Wdata;
  logic [DW-1:0] M_Rdata;
  logic          M_Ready;

  logic          Stall_IF;
  logic          Stall_MEM;

  modport slave (
    input  I_Req, I_Addr,
    input  D_Req, D_We, D_Addr, D_Wdata,
    input  M_Rdata, M_Ready,
    output I_Rdata, I_Ack,
    output D_Rdata, D_Ack,
    output M_Req, M_We, M_Addr, M_Wdata,
    output Stall_IF, Stall_MEM
  );

  modport master (
    output I_Req, I_Addr,
    output D_Req, D_We, D_Addr, D_Wdata,
    output M_Rdata, M_Ready,
    input  I_Rdata, I_Ack,
    input  D_Rdata, D_Ack,
    input  M_Req, M_We, M_Addr, M_Wdata,
    input  Stall_IF, Stall_MEM
  );

endinterface

// File: rtl/ppcpu_mem_arbiter_starve_cnt.sv
// Saturating count of D grants taken while fetch waits.
// sat tells the picker that fetch must win next.
module ppcpu_mem_arbiter_starve_cnt #(
  parameter int MAX_IF_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int CW = $clog2(MAX_IF_WAIT + 1);

  logic [CW-1:0] cnt;

  assign sat = (cnt == CW'(MAX_IF_WAIT));

  // clear wins; increment stops at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ppcpu_mem_arbiter.sv
// Shares one variable-latency memory between fetch and data.
// Serialises accesses, returns read data, pulses acks, stalls.
module ppcpu_mem_arbiter
  import ppcpu_mem_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_IF_WAIT = MAX_IF_WAIT_DEF
) (
  input logic                Clk,
  input logic                Clrn,
  ppcpu_mem_arbiter_if.slave bus
);

  arb_state_e    state_q;
  arb_state_e    state_d;
  grant_e        gnt;
  logic          done;
  logic          i_elig;
  logic          d_elig;
  logic          starved;
  logic          st_inc;
  logic          st_clr;

  logic          m_req_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;
  logic          i_ack_q;
  logic          d_ack_q;

  assign i_elig = bus.I_Req & ~i_ack_q;
  assign d_elig = bus.D_Req & ~d_ack_q;

  assign st_inc = (gnt == GNT_D) & bus.I_Req;
  assign st_clr = (gnt == GNT_I) | ~bus.I_Req;

  ppcpu_mem_arbiter_starve_cnt #(
    .MAX_IF_WAIT(MAX_IF_WAIT)
  ) u_starve (
    .clk  (Clk),
    .rst_n(Clrn),
    .inc  (st_inc),
    .clr  (st_clr),
    .sat  (starved)
  );

  // state register
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // grant in idle, finish on ready
  always_comb begin
    state_d = state_q;
    gnt     = GNT_NONE;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        gnt = pick_winner(i_elig, d_elig, starved);
        if (gnt == GNT_I) state_d = ST_BUSY_I;
        if (gnt == GNT_D) state_d = ST_BUSY_D;
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (bus.M_Ready) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // memory-side request, frozen while busy
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else if (gnt == GNT_I) begin
      m_req_q  <= 1'b1;
      m_we_q   <= 1'b0;
      m_addr_q <= bus.I_Addr;
    end else if (gnt == GNT_D) begin
      m_req_q   <= 1'b1;
      m_we_q    <= bus.D_We;
      m_addr_q  <= bus.D_Addr;
      m_wdata_q <= bus.D_Wdata;
    end else if (done) begin
      m_req_q <= 1'b0;
    end
  end

  // one-cycle acks and read data capture
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_ack_q <= done && (state_q == ST_BUSY_I);
      d_ack_q <= done && (state_q == ST_BUSY_D);
      if (done && (state_q == ST_BUSY_I)) begin
        i_rdata_q <= bus.M_Rdata;
      end
      if (done && (state_q == ST_BUSY_D) && !m_we_q) begin
        d_rdata_q <= bus.M_Rdata;
      end
    end
  end

  assign bus.M_Req     = m_req_q;
  assign bus.M_We      = m_we_q;
  assign bus.M_Addr    = m_addr_q;
  assign bus.M_Wdata   = m_wdata_q;
  assign bus.I_Rdata   = i_rdata_q;
  assign bus.D_Rdata   = d_rdata_q;
  assign bus.I_Ack     = i_ack_q;
  assign bus.D_Ack     = d_ack_q;
  assign bus.Stall_IF  = bus.I_Req & ~i_ack_q;
  assign bus.Stall_MEM = bus.D_Req & ~d_ack_q;

endmodule
